// File: rtl/f2c_queue_if.sv
// Opcode type shared by the ring and core sides, plus the ring/core handshake bundle of f2c_queue.
// The queue connects to the slave modport; the ring and core models connect to the master modport.
package f2c_pkg;
  typedef enum logic [1:0] {RD = 2'd0, WR = 2'd1, WR_BCAST = 2'd2, RD_RSP = 2'd3} t_opcode;
endpackage

interface f2c_queue_if
  import f2c_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RQID_W  = 10
);
  localparam int TAG_W = $clog2(ENTRIES);

  logic              RingReqInValid;
  logic [RQID_W-1:0] RingReqInRequestor;
  t_opcode           RingReqInOpcode;
  logic [ADDR_W-1:0] RingReqInAddress;
  logic [DATA_W-1:0] RingReqInData;
  logic              MatchId;
  logic              RingReqInAccept;

  logic              RingRspOutValid;
  logic              RingRspOutReady;
  logic [RQID_W-1:0] RingRspOutRequestor;
  t_opcode           RingRspOutOpcode;
  logic [ADDR_W-1:0] RingRspOutAddress;
  logic [DATA_W-1:0] RingRspOutData;

  logic              CoreReqValid;
  logic              CoreReqReady;
  t_opcode           CoreReqOpcode;
  logic [ADDR_W-1:0] CoreReqAddress;
  logic [DATA_W-1:0] CoreReqData;
  logic [TAG_W-1:0]  CoreReqTag;

  logic              CoreRspValid;
  logic [TAG_W-1:0]  CoreRspTag;
  logic [DATA_W-1:0] CoreRspData;

  modport slave (
    input  RingReqInValid, RingReqInRequestor, RingReqInOpcode, RingReqInAddress, RingReqInData,
    output MatchId, RingReqInAccept,
    output RingRspOutValid, RingRspOutRequestor, RingRspOutOpcode, RingRspOutAddress, RingRspOutData,
    input  RingRspOutReady,
    output CoreReqValid, CoreReqOpcode, CoreReqAddress, CoreReqData, CoreReqTag,
    input  CoreReqReady,
    input  CoreRspValid, CoreRspTag, CoreRspData
  );

  modport master (
    output RingReqInValid, RingReqInRequestor, RingReqInOpcode, RingReqInAddress, RingReqInData,
    input  MatchId, RingReqInAccept,
    input  RingRspOutValid, RingRspOutRequestor, RingRspOutOpcode, RingRspOutAddress, RingRspOutData,
    output RingRspOutReady,
    input  CoreReqValid, CoreReqOpcode, CoreReqAddress, CoreReqData, CoreReqTag,
    output CoreReqReady,
    output CoreRspValid, CoreRspTag, CoreRspData
  );
endinterface

// File: rtl/f2c_queue.sv
// Fabric-to-core request queue: buffers ring requests for this core, issues them oldest-first,
// and returns read data to the ring oldest-first.
//   state      | meaning
//   FREE       | entry unused
//   WRITE      | write waiting to be taken by the core
//   READ       | read waiting to be taken by the core
//   READ_PRGRS | read issued, waiting for core data
//   READ_RDY   | read data held, waiting for the ring
module f2c_queue
  import f2c_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RQID_W   = 10,
  parameter int COREID_W = 8
) (
  input  logic                         QClk,
  input  logic                         RstQnnnH,
  input  logic [COREID_W-1:0]          CoreID,
  f2c_queue_if.slave                   bus,
  output logic [$clog2(ENTRIES+1)-1:0] Occupancy,
  output logic                         ErrStray
);
  localparam int TAG_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES + 1);

  typedef enum logic [2:0] {FREE, WRITE, READ, READ_PRGRS, READ_RDY} t_ent_state;

  t_ent_state        ent_state [ENTRIES];
  logic [RQID_W-1:0] ent_rqid  [ENTRIES];
  logic [ADDR_W-1:0] ent_addr  [ENTRIES];
  logic [DATA_W-1:0] ent_data  [ENTRIES];

  // age[i][j] set means entry i was allocated before entry j
  logic [ENTRIES-1:0][ENTRIES-1:0] age, age_nxt;

  logic [ENTRIES-1:0] free_vec, core_elig, ring_elig;
  logic [TAG_W-1:0]   alloc_idx, core_idx, ring_idx, core_lock_idx, ring_lock_idx;
  logic               core_lock, ring_lock;
  logic               id_match, alloc, core_hs, core_free, ring_hs, rsp_hit;

  function automatic logic [TAG_W-1:0] pick_oldest(input logic [ENTRIES-1:0] elig,
                                                   input logic [ENTRIES-1:0][ENTRIES-1:0] age_m);
    logic [TAG_W-1:0] idx;
    logic             found;
    logic             older;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      older = 1'b0;
      for (int j = 0; j < ENTRIES; j++)
        if (elig[j] && age_m[j][i]) older = 1'b1;
      if (!found && elig[i] && !older) begin
        idx   = TAG_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_comb begin
    free_vec  = '0;
    core_elig = '0;
    ring_elig = '0;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_vec[i]  = (ent_state[i] == FREE);
      core_elig[i] = (ent_state[i] == READ) || (ent_state[i] == WRITE);
      ring_elig[i] = (ent_state[i] == READ_RDY);
      if (ent_state[i] == FREE) alloc_idx = TAG_W'(i);
    end
  end

  assign id_match = (bus.RingReqInAddress[ADDR_W-1 -: COREID_W] == CoreID);
  assign bus.MatchId = bus.RingReqInValid && (bus.RingReqInOpcode != RD_RSP) &&
                       (id_match || (bus.RingReqInOpcode == WR_BCAST));
  assign alloc = bus.MatchId && (|free_vec);
  assign bus.RingReqInAccept = alloc;

  // A stalled offer stays locked on its entry so the payload cannot switch under the consumer
  assign core_idx = core_lock ? core_lock_idx : pick_oldest(core_elig, age);
  assign ring_idx = ring_lock ? ring_lock_idx : pick_oldest(ring_elig, age);

  assign bus.CoreReqValid   = core_lock || (|core_elig);
  assign bus.CoreReqOpcode  = (ent_state[core_idx] == READ) ? RD : WR;
  assign bus.CoreReqAddress = ent_addr[core_idx];
  assign bus.CoreReqData    = ent_data[core_idx];
  assign bus.CoreReqTag     = core_idx;

  assign bus.RingRspOutValid     = ring_lock || (|ring_elig);
  assign bus.RingRspOutOpcode    = RD_RSP;
  assign bus.RingRspOutRequestor = ent_rqid[ring_idx];
  assign bus.RingRspOutAddress   = ent_addr[ring_idx];
  assign bus.RingRspOutData      = ent_data[ring_idx];

  assign core_hs   = bus.CoreReqValid && bus.CoreReqReady;
  assign core_free = core_hs && (ent_state[core_idx] == WRITE);
  assign ring_hs   = bus.RingRspOutValid && bus.RingRspOutReady;
  assign rsp_hit   = bus.CoreRspValid && (int'(bus.CoreRspTag) < ENTRIES) &&
                     (ent_state[bus.CoreRspTag] == READ_PRGRS);

  always_comb begin
    age_nxt = age;
    if (alloc) begin
      for (int j = 0; j < ENTRIES; j++) begin
        age_nxt[alloc_idx][j] = 1'b0;
        age_nxt[j][alloc_idx] = !free_vec[j];
      end
    end
    for (int j = 0; j < ENTRIES; j++) begin
      if (core_free) begin
        age_nxt[core_idx][j] = 1'b0;
        age_nxt[j][core_idx] = 1'b0;
      end
      if (ring_hs) begin
        age_nxt[ring_idx][j] = 1'b0;
        age_nxt[j][ring_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      for (int i = 0; i < ENTRIES; i++) ent_state[i] <= FREE;
      age           <= '0;
      core_lock     <= 1'b0;
      ring_lock     <= 1'b0;
      core_lock_idx <= '0;
      ring_lock_idx <= '0;
      Occupancy     <= '0;
      ErrStray      <= 1'b0;
    end else begin
      age           <= age_nxt;
      core_lock     <= bus.CoreReqValid && !bus.CoreReqReady;
      core_lock_idx <= core_idx;
      ring_lock     <= bus.RingRspOutValid && !bus.RingRspOutReady;
      ring_lock_idx <= ring_idx;
      Occupancy     <= Occupancy + OCC_W'(alloc) - OCC_W'(core_free) - OCC_W'(ring_hs);
      if (bus.CoreRspValid && !rsp_hit) ErrStray <= 1'b1;
      if (core_hs) ent_state[core_idx] <= (ent_state[core_idx] == READ) ? READ_PRGRS : FREE;
      if (rsp_hit) ent_state[bus.CoreRspTag] <= READ_RDY;
      if (ring_hs) ent_state[ring_idx] <= FREE;
      if (alloc)   ent_state[alloc_idx] <= (bus.RingReqInOpcode == RD) ? READ : WRITE;
    end
  end

  always_ff @(posedge QClk) begin
    if (alloc) begin
      ent_rqid[alloc_idx] <= bus.RingReqInRequestor;
      ent_addr[alloc_idx] <= bus.RingReqInAddress;
      ent_data[alloc_idx] <= bus.RingReqInData;
    end
    if (rsp_hit) ent_data[bus.CoreRspTag] <= bus.CoreRspData;
  end
endmodule

// File: doc/f2c_queue.md
F2C_QUEUE -- requirements
Module: f2c_queue

Interface
REQ-001 SHALL have parameter ENTRIES, default 4: buffer depth, legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 32: address width, minimum 16.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have parameter RQID_W, default 10: requestor ID width.
REQ-005 SHALL have parameter COREID_W, default 8: core ID width; the ID field is Address[ADDR_W-1 -: COREID_W].
REQ-006 SHALL have the following ports, where TAG_W = clog2(ENTRIES):
- QClk  in  1  single clock; all flops rise on it.
- RstQnnnH  in  1  asynchronous, active-low reset.
- CoreID  in  COREID_W  ID of this core.
- RingReqInValid/Requestor/Opcode/Address/Data  in  1/RQID_W/t_opcode/ADDR_W/DATA_W  request arriving from the ring.
- MatchId  out  1  the ring request targets this core.
- RingReqInAccept  out  1  the matched request is taken this cycle.
- RingRspOutValid  out  1  read response offered to the ring.
- RingRspOutReady  in  1  the ring arbiter takes the response.
- RingRspOutRequestor/Opcode/Address/Data  out  RQID_W/t_opcode/ADDR_W/DATA_W  response payload.
- CoreReqValid  out  1  request offered to the core.
- CoreReqReady  in  1  the core takes the request.
- CoreReqOpcode/Address/Data/Tag  out  t_opcode/ADDR_W/DATA_W/TAG_W  request payload.
- CoreRspValid/Tag/Data  in  1/TAG_W/DATA_W  read data returned by the core.
- Occupancy  out  clog2(ENTRIES+1)  number of non-FREE entries, registered.
- ErrStray  out  1  sticky flag for an unmatched core response.

Function
REQ-007 MatchId SHALL equal RingReqInValid AND Opcode!=RD_RSP AND (ID field==CoreID OR Opcode==WR_BCAST).
REQ-008 RingReqInAccept SHALL equal MatchId AND (at least one entry is FREE in the current state).
REQ-009 On accept, SHALL allocate the lowest-index FREE entry at the next edge.
- Capture requestor, address and data.
- Set state: RD→READ; WR or WR_BCAST→WRITE.
REQ-010 A matched request arriving while full SHALL not be accepted, and no state SHALL change; the ring keeps circulating the request.
REQ-011 An entry freed in cycle N SHALL NOT be reallocated in cycle N.
REQ-012 Per-entry states SHALL be FREE, WRITE, READ, READ_PRGRS and READ_RDY, with these transitions:
- WRITE→FREE on core handshake.
- READ→READ_PRGRS on core handshake.
- READ_PRGRS→READ_RDY on CoreRspValid with matching Tag.
- READ_RDY→FREE on ring handshake.
REQ-013 Core handshake SHALL be CoreReqValid AND CoreReqReady. The presented entry SHALL be the oldest entry (by allocation order) in READ or WRITE.
REQ-014 CoreReqTag SHALL be the presented entry's index. CoreReqOpcode SHALL be RD for READ and WR for WRITE.
REQ-015 Ring handshake SHALL be RingRspOutValid AND RingRspOutReady. The presented entry SHALL be the oldest entry in READ_RDY.
REQ-016 RingRspOut SHALL carry Opcode=RD_RSP plus the entry's stored requestor, address and read data.
REQ-017 While a Valid is high and its Ready is low, the selected entry and payload on that port SHALL stay stable until the handshake, even if an older entry becomes eligible.
REQ-018 Age ordering SHALL be tracked with an ENTRIES×ENTRIES age matrix.
- Allocation marks the new entry younger than all occupied entries.
- Freeing clears the entry's row and column.
REQ-019 A CoreRspValid whose Tag is not in READ_PRGRS SHALL be dropped and SHALL set ErrStray, which holds until reset.
REQ-020 Latency SHALL be:
- Accept in cycle N → earliest CoreReqValid in cycle N+1.
- CoreRsp in cycle M → earliest RingRspOutValid in cycle M+1.
REQ-021 Core handshake, core response, ring handshake and ring allocation SHALL all be processed in the same cycle when they target different entries.
REQ-022 Occupancy SHALL update each cycle by (+1 allocate) and (−1 per entry freed), never wrapping, range 0..ENTRIES.
REQ-023 Write-data flops SHALL load only on allocation or core-response match. Address and requestor flops SHALL load only on allocation.

Reset
REQ-024 On RstQnnnH low, at any time including mid-transaction, SHALL take effect immediately:
- All entries FREE; age matrix cleared.
- Occupancy=0 and ErrStray=0.
- RingRspOutValid=0 and CoreReqValid=0; in-flight transactions are discarded.
REQ-025 After reset release, RingReqInAccept SHALL equal MatchId, since all entries are FREE.

Verification
REQ-026 CoreID=0x05, RD to address 0x0500_0010, requestor 0x1A3; core accepts, returns Tag 0 with data 0xDEADBEEF → RingRspOut gives RD_RSP, requestor 0x1A3, address 0x0500_0010, data 0xDEADBEEF, and Occupancy returns to 0.
REQ-027 ENTRIES=4, five back-to-back WR with CoreReqReady=0 → four accepted, fifth has RingReqInAccept=0, Occupancy=4; on release the core sees the four writes in arrival order.
REQ-028 Two RDs (tags 0, 1); core responds tag 1 then tag 0 with RingRspOutReady=0 → tag-1 response presented first and held stable; on ready, tag 1 then tag 0 are issued.
REQ-029 WR_BCAST with a foreign ID field → accepted. RD_RSP addressed to this core → MatchId=0.
REQ-030 CoreRspValid with Tag=2 while entry 2 is FREE → ErrStray=1 and no state change; assert reset mid-read → all outputs at reset values immediately.
